sync_peak_correlator: RTL and testbench

- Downstream of the RX sync-word shift register. It consumes the 64-bit sliding sync word (LSB received first) once per microsecond.
- Each microsecond it compares the word with the reference access code and counts matching bits in a 2-stage pipeline.
- While the correlation window is open, it qualifies hits against the programmed mismatch threshold and tracks the peak score.
- It emits a single-cycle trigger (pscorr_trgp) at the best-aligned bit; the packet timing and header stages consume that trigger.

---
 rtl/sync_peak_correlator_pkg.sv | 30 +++
 rtl/sync_peak_correlator_popcount64.sv | 71 +++++++
 rtl/sync_peak_correlator.sv | 162 ++++++++++++++++
 tb/tb_sync_peak_correlator.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_peak_correlator_pkg.sv
// ---------------------------------------------------------------------------
// sync_peak_correlator_pkg
// Shared definitions for the sync-word peak correlator:
//   SYNC_W / SCORE_W : sync word width and match-score width (0..64)
//   corr_state_t     : correlator FSM encoding (IDLE/SEARCH/TRACK/DONE)
//   popcount8        : ones count of one byte
// ---------------------------------------------------------------------------
package sync_peak_correlator_pkg;

    localparam int unsigned SYNC_W  = 64;
    localparam int unsigned SCORE_W = 7;
    localparam int unsigned NBYTE   = SYNC_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2,
        DONE   = 2'd3
    } corr_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + {3'b000, b[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_peak_correlator_popcount64.sv
// ---------------------------------------------------------------------------
// sync_popcount64
// Two-stage registered match counter between the received sync word and the
// reference access code.
//   clk_6M, rstz : clock, asynchronous active-low reset
//   p_1us        : per-bit strobe; sync_in is taken one cycle later
//   sync_in      : sliding received word
//   ref_sync     : reference word
//   s2_vld       : high in the cycle the new total is on score_sum
//   score_sum    : combinational total of the registered byte counts
//   corr_score   : registered total, updates 2 clk_6M after p_1us
// ---------------------------------------------------------------------------
module sync_popcount64
    import sync_peak_correlator_pkg::*;
(
    input  logic               clk_6M,
    input  logic               rstz,
    input  logic               p_1us,
    input  logic [SYNC_W-1:0]  sync_in,
    input  logic [SYNC_W-1:0]  ref_sync,
    output logic               s2_vld,
    output logic [SCORE_W-1:0] score_sum,
    output logic [SCORE_W-1:0] corr_score
);

    logic                 s1_vld;
    logic [3:0]           byte_cnt [NBYTE];
    logic [SYNC_W-1:0]    match_bits;

    assign match_bits = ~(sync_in ^ ref_sync);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= p_1us;
            s2_vld <= s1_vld;
        end
    end

    // Stage 1: sampled one cycle after p_1us so the shifted word is used.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                byte_cnt[i] <= '0;
            end
        end else if (s1_vld) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                byte_cnt[i] <= popcount8(match_bits[i*8 +: 8]);
            end
        end
    end

    always_comb begin
        score_sum = '0;
        for (int unsigned i = 0; i < NBYTE; i++) begin
            score_sum = score_sum + {3'b000, byte_cnt[i]};
        end
    end

    // Stage 2
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            corr_score <= '0;
        end else if (s2_vld) begin
            corr_score <= score_sum;
        end
    end

endmodule

// File: rtl/sync_peak_correlator.sv
// ---------------------------------------------------------------------------
// sync_peak_correlator
// Correlates the sliding RX sync word against the access code once per bit,
// qualifies hits against a mismatch threshold while correWindow is open,
// tracks the best score and emits one trigger at the best-aligned bit.
//   clk_6M, rstz        : 6 MHz clock, asynchronous active-low reset
//   p_1us               : per-bit strobe
//   correWindow         : correlation permitted while high
//   sync_in, ref_sync   : received / expected 64-bit words
//   regi_correthreshold : maximum mismatching bits for a hit
//   pscorr_trgp         : one-cycle trigger at the peak
//   corr_score          : latest match count
//   peak_score/peak_pos : best score of the window and its bit index
//   corr_busy           : high in SEARCH or TRACK
//   peak_inv            : (SYNC_CORR_INV_EN only) peak came from ~ref match
// Optional feature macro: SYNC_CORR_INV_EN (inverted sync detection).
// ---------------------------------------------------------------------------
module sync_peak_correlator
    import sync_peak_correlator_pkg::*;
#(
    parameter int unsigned PEAK_WAIT = 2,
    parameter int unsigned WIN_CNT_W = 10
) (
    input  logic                 clk_6M,
    input  logic                 rstz,
    input  logic                 p_1us,
    input  logic                 correWindow,
    input  logic [SYNC_W-1:0]    sync_in,
    input  logic [SYNC_W-1:0]    ref_sync,
    input  logic [5:0]           regi_correthreshold,
    output logic                 pscorr_trgp,
    output logic [SCORE_W-1:0]   corr_score,
    output logic [SCORE_W-1:0]   peak_score,
    output logic [WIN_CNT_W-1:0] peak_pos,
    output logic                 corr_busy
`ifdef SYNC_CORR_INV_EN
    ,
    output logic                 peak_inv
`endif
);

    localparam int unsigned        WAIT_W    = $clog2(PEAK_WAIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(PEAK_WAIT);

    corr_state_t          state_q, state_d;
    logic                 s2_vld;
    logic [SCORE_W-1:0]   score_sum;
    logic [SCORE_W-1:0]   thr_floor;
    logic [SCORE_W-1:0]   eff_score;
    logic                 eff_inv;
    logic                 hit;
    logic                 better;
    logic                 wait_last;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WIN_CNT_W-1:0] win_cnt;

    sync_popcount64 u_popcount (
        .clk_6M     (clk_6M),
        .rstz       (rstz),
        .p_1us      (p_1us),
        .sync_in    (sync_in),
        .ref_sync   (ref_sync),
        .s2_vld     (s2_vld),
        .score_sum  (score_sum),
        .corr_score (corr_score)
    );

    // Qualification uses score_sum, the value corr_score takes on this edge.
    always_comb begin
        thr_floor = SCORE_W'(SYNC_W) - {1'b0, regi_correthreshold};
        eff_score = score_sum;
        eff_inv   = 1'b0;
        hit       = (score_sum >= thr_floor);
`ifdef SYNC_CORR_INV_EN
        if ((SCORE_W'(SYNC_W) - score_sum) > score_sum) begin
            eff_score = SCORE_W'(SYNC_W) - score_sum;
            eff_inv   = 1'b1;
        end
        hit = hit || (score_sum <= {1'b0, regi_correthreshold});
`endif
        better    = hit && (eff_score > peak_score);
        wait_last = (wait_cnt <= WAIT_W'(1));
    end

    // State register
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a window close takes priority over any in-flight result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (correWindow) state_d = SEARCH;
            SEARCH: begin
                if (!correWindow)         state_d = IDLE;
                else if (s2_vld && hit)   state_d = TRACK;
            end
            TRACK: begin
                if (!correWindow)                          state_d = IDLE;
                else if (s2_vld && !better && wait_last)   state_d = DONE;
            end
            DONE:   if (!correWindow) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        corr_busy   = (state_q == SEARCH) || (state_q == TRACK);
        pscorr_trgp = (state_q == TRACK) &&
                      (!correWindow || (s2_vld && !better && wait_last));
    end

    // Window counter, wait counter and peak registers
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            win_cnt    <= '0;
            wait_cnt   <= '0;
            peak_score <= '0;
            peak_pos   <= '0;
`ifdef SYNC_CORR_INV_EN
            peak_inv   <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && correWindow) begin
                win_cnt    <= '0;
                wait_cnt   <= '0;
                peak_score <= '0;
                peak_pos   <= '0;
`ifdef SYNC_CORR_INV_EN
                peak_inv   <= 1'b0;
`endif
            end else if ((state_q == SEARCH || state_q == TRACK) &&
                         correWindow && s2_vld) begin
                if (win_cnt != '1) begin
                    win_cnt <= win_cnt + 1'b1;
                end
                if ((state_q == SEARCH) ? hit : better) begin
                    peak_score <= eff_score;
                    peak_pos   <= win_cnt;
                    wait_cnt   <= WAIT_LOAD;
`ifdef SYNC_CORR_INV_EN
                    peak_inv   <= eff_inv;
`endif
                end else if (state_q == TRACK && wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

`ifndef SYNC_CORR_INV_EN
    logic unused_inv;
    assign unused_inv = eff_inv;
`endif

endmodule

// File: tb/tb_sync_peak_correlator.sv
// ---------------------------------------------------------------------------
// tb_sync_peak_correlator
// Directed bench: each driven bit pushes its expected score (and, through a
// bit-level model of the window behaviour, any expected trigger cycle) into
// queues that monitors pop when the DUT produces the result.
// ---------------------------------------------------------------------------
module tb_sync_peak_correlator;

    localparam int PW = 2;
    localparam logic [63:0] REF  = 64'h4E1C_3F2A_9B07_D561;
    localparam logic [63:0] FILL = REF ^ 64'hFFFF_FFFF_0000_0000;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b0;
    logic        p_1us = 1'b0;
    logic        correWindow = 1'b0;
    logic [63:0] sync_in = '0;
    logic [63:0] ref_sync = REF;
    logic [5:0]  thr = 6'd5;
    logic        pscorr_trgp;
    logic [6:0]  corr_score;
    logic [6:0]  peak_score;
    logic [9:0]  peak_pos;
    logic        corr_busy;
`ifdef SYNC_CORR_INV_EN
    logic        peak_inv;
`endif

    sync_peak_correlator #(.PEAK_WAIT(PW), .WIN_CNT_W(10)) dut (
        .clk_6M              (clk_6M),
        .rstz                (rstz),
        .p_1us               (p_1us),
        .correWindow         (correWindow),
        .sync_in             (sync_in),
        .ref_sync            (ref_sync),
        .regi_correthreshold (thr),
        .pscorr_trgp         (pscorr_trgp),
        .corr_score          (corr_score),
        .peak_score          (peak_score),
        .peak_pos            (peak_pos),
        .corr_busy           (corr_busy)
`ifdef SYNC_CORR_INV_EN
        ,
        .peak_inv            (peak_inv)
`endif
    );

    always #5 clk_6M = ~clk_6M;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int score_q[$];
    int exp_trg[$];
    int act_trg[$];
    logic [2:0] p1_d;

    // bit-level model state: 0 idle, 1 search, 2 track, 3 done
    int m_st = 0, m_idx = 0, m_peak = 0, m_pos = 0, m_wait = 0;
    bit m_inv = 1'b0;

    always @(posedge clk_6M) cyc <= cyc + 1;

    always @(posedge clk_6M or negedge rstz) begin
        if (!rstz) p1_d <= '0;
        else       p1_d <= {p1_d[1:0], p_1us};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: triggers and per-bit scores.
    always @(negedge clk_6M) begin
        if (pscorr_trgp === 1'b1) act_trg.push_back(cyc);
        if (p1_d[2]) begin
            checks++;
            assert (score_q.size() > 0) else begin
                errors++;
                $error("FAIL corr_score_unexpected observed=%0d expected=none", corr_score);
            end
            if (score_q.size() > 0) begin
                chk("corr_score", 64'(corr_score), 64'(score_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_6M);
        #1;
    endtask

    task automatic model_bit(input int s, input int pc);
        int eff;
        bit inv;
        bit hit;
        eff = s;
        inv = 1'b0;
        hit = (s >= 64 - int'(thr));
`ifdef SYNC_CORR_INV_EN
        if (64 - s > s) begin
            eff = 64 - s;
            inv = 1'b1;
        end
        hit = hit || (s <= int'(thr));
`endif
        if (m_st == 1) begin
            if (hit) begin
                m_st = 2; m_peak = eff; m_pos = m_idx; m_wait = PW; m_inv = inv;
            end
            m_idx++;
        end else if (m_st == 2) begin
            if (hit && eff > m_peak) begin
                m_peak = eff; m_pos = m_idx; m_wait = PW; m_inv = inv;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_st = 3;
                    exp_trg.push_back(pc + 2);
                end
            end
            m_idx++;
        end
    endtask

    task automatic send_raw(input logic [63:0] w);
        int s;
        sync_in = w;
        p_1us = 1'b1;
        s = 64 - $countones(w ^ ref_sync);
        score_q.push_back(s);
        model_bit(s, cyc);
        tick(1);
        p_1us = 1'b0;
        tick(5);
    endtask

    task automatic send_bit(input logic b);
        send_raw({b, sync_in[63:1]});
    endtask

    task automatic fillers(input int n);
        for (int i = 0; i < n; i++) send_raw(FILL);
    endtask

    task automatic open_win(input string tag);
        correWindow = 1'b1;
        m_st = 1; m_idx = 0; m_peak = 0; m_pos = 0; m_wait = 0; m_inv = 1'b0;
        tick(2);
        chk({tag, "_busy_open"}, 64'(corr_busy), 64'd1);
    endtask

    task automatic close_win(input string tag);
        correWindow = 1'b0;
        if (m_st == 2) exp_trg.push_back(cyc);
        m_st = 0;
        tick(2);
        chk({tag, "_busy_closed"}, 64'(corr_busy), 64'd0);
    endtask

    task automatic check_trg(input string tag);
        int n;
        chk({tag, "_trg_count"}, 64'(act_trg.size()), 64'(exp_trg.size()));
        n = (act_trg.size() < exp_trg.size()) ? act_trg.size() : exp_trg.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_trg_cycle"}, 64'(act_trg[i]), 64'(exp_trg[i]));
        end
        act_trg.delete();
        exp_trg.delete();
    endtask

    task automatic check_peak(input string tag);
        chk({tag, "_peak_score"}, 64'(peak_score), 64'(m_peak));
        chk({tag, "_peak_pos"}, 64'(peak_pos), 64'(m_pos));
`ifdef SYNC_CORR_INV_EN
        chk({tag, "_peak_inv"}, 64'(peak_inv), 64'(m_inv));
`endif
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_trgp", 64'(pscorr_trgp), 64'd0);
        chk("rst_score", 64'(corr_score), 64'd0);
        chk("rst_peak", 64'(peak_score), 64'd0);
        chk("rst_pos", 64'(peak_pos), 64'd0);
        chk("rst_busy", 64'(corr_busy), 64'd0);
        rstz = 1'b1;
        tick(2);

        // Exact sync streamed LSB first, threshold 5
        thr = 6'd5;
        sync_in = FILL;
        open_win("exact");
        for (int i = 0; i < 64; i++) send_bit(REF[i]);
        fillers(3);
        check_trg("exact");
        chk("exact_peak64", 64'(peak_score), 64'd64);
        chk("exact_pos63", 64'(peak_pos), 64'd63);
        check_peak("exact");
        close_win("exact");
        check_trg("exact_close");

        // Three bit errors: threshold 2 misses, threshold 3 hits
        thr = 6'd2;
        sync_in = FILL;
        open_win("err_thr2");
        for (int i = 0; i < 64; i++) send_bit(REF[i] ^ ((i == 3) || (i == 20) || (i == 50)));
        fillers(3);
        chk("err_thr2_still_search", 64'(corr_busy), 64'd1);
        close_win("err_thr2");
        check_trg("err_thr2");
        thr = 6'd3;
        sync_in = FILL;
        open_win("err_thr3");
        for (int i = 0; i < 64; i++) send_bit(REF[i] ^ ((i == 3) || (i == 20) || (i == 50)));
        fillers(3);
        check_trg("err_thr3");
        chk("err_thr3_peak61", 64'(peak_score), 64'd61);
        check_peak("err_thr3");
        close_win("err_thr3");

        // Score 60 then 63 on the next bit
        thr = 6'd5;
        open_win("move");
        send_raw(FILL);
        send_raw(REF ^ 64'h8000_0000_0000_000E);
        send_raw(REF ^ 64'h0000_0100_0000_0000);
        fillers(3);
        check_trg("move");
        chk("move_peak63", 64'(peak_score), 64'd63);
        chk("move_pos2", 64'(peak_pos), 64'd2);
        close_win("move");

        // Score 62 then window dropped while waiting
        open_win("drop");
        send_raw(FILL);
        send_raw(REF ^ 64'h0000_0000_0000_0003);
        close_win("drop");
        check_trg("drop");
        chk("drop_peak62", 64'(peak_score), 64'd62);

        // Repeat within the window: one trigger only; reopen allows another
        open_win("rpt");
        send_raw(REF);
        fillers(3);
        send_raw(REF);
        fillers(3);
        check_trg("rpt");
        close_win("rpt");
        open_win("reopen");
        send_raw(REF);
        fillers(3);
        check_trg("reopen");
        check_peak("reopen");
        close_win("reopen");

`ifdef SYNC_CORR_INV_EN
        // Inverted sync word
        open_win("inv");
        send_raw(FILL);
        send_raw(~REF);
        fillers(3);
        check_trg("inv");
        chk("inv_flag", 64'(peak_inv), 64'd1);
        chk("inv_peak64", 64'(peak_score), 64'd64);
        close_win("inv");
`endif

        // Reset asserted mid-TRACK
        open_win("rst");
        send_raw(REF ^ 64'h1);
        rstz = 1'b0;
        m_st = 0;
        #1;
        chk("midrst_trgp", 64'(pscorr_trgp), 64'd0);
        chk("midrst_score", 64'(corr_score), 64'd0);
        chk("midrst_peak", 64'(peak_score), 64'd0);
        chk("midrst_pos", 64'(peak_pos), 64'd0);
        chk("midrst_busy", 64'(corr_busy), 64'd0);
        tick(2);
        correWindow = 1'b0;
        rstz = 1'b1;
        tick(4);
        chk("midrst_idle", 64'(corr_busy), 64'd0);
        check_trg("midrst");

        chk("score_q_drain", 64'(score_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
